seven_segment_display: RTL and testbench
========================================

# seven_segment_display

Registered BCD/hex to seven-segment decoder driving one digit of the front-panel display. Accepts a 4-bit code `A` and produces the seven segment enables `a`..`g` (active-high, segment `a` top, clockwise, `g` middle), with lamp-test, blanking and ripple-blanking for leading-zero suppression in multi-digit chains. It sits between the digit-value logic and the display pins, with one instance per digit.

## Interface
- No parameters. Build-time options are covered under Configuration.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `A`  in  4  digit code, `A[3]` MSB.
- `lt_n`  in  1  lamp test, active-low; forces all segments on.
- `bl_n`  in  1  blank, active-low; forces all segments off.
- `rbi_n`  in  1  ripple-blank in, active-low; blanks the digit when `A` == 0.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`  out  1 each  segment enables, 1 = lit.
- `rbo_n`  out  1  ripple-blank out, active-low; drives the next lower digit's `rbi_n`.
- `inv`  out  1  high when `A` is not a displayable code in the current build.

## Operation
- Segment patterns `{a,b,c,d,e,f,g}` for `A` = 0..9:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Hex glyphs for `A` = 10..15, used only with HEX_EN:
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Priority per cycle, highest first:
  1. `rst_n` = 0: segments 0000000, `rbo_n` = 1, `inv` = 0.
  2. `lt_n` = 0: segments 1111111, `rbo_n` = 1, `inv` still computed from `A`.
  3. `bl_n` = 0: segments 0000000, `rbo_n` = 1.
  4. `rbi_n` = 0 and `A` = 0: segments 0000000, `rbo_n` = 0.
  5. Otherwise: decoded pattern, `rbo_n` = 1.
- Unsupported code (`A` >= 10 without HEX_EN):
  - Segments 0000000 and `inv` = 1.
  - Lamp test and blank still override the segments.
- `inv` is 0 for every supported code and is independent of `bl_n` and `rbi_n`.
- Invariant: at most one of lamp-test and blank affects the segments in a given cycle.

## Timing
- All outputs are registered.
- Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- The outputs hold between edges and are glitch-free.
- Reset is synchronous. Asserting `rst_n` mid-stream clears the outputs at the next edge. The first edge with `rst_n` = 1 loads the decode of the inputs present at that edge.
- No handshake: a new code is accepted every cycle.
- Ripple chain: `rbo_n` is registered, so a digit fed by an upstream `rbo_n` sees it one cycle late. Multi-digit suppression settles in (number of digits) cycles after a value change; the display is allowed to be transient during settling.

## Configuration
- Macro: `SEVEN_SEG_HEX_EN`.
- Defined: codes 10..15 show the hex glyphs above and `inv` never asserts.
- Undefined: codes 10..15 blank the digit and assert `inv`. Codes 0..9 behave identically in both builds.

## Test plan
- Reset: hold `rst_n` = 0 with `A` = 8 and `lt_n` = 0 for 3 cycles -> segments 0000000, `rbo_n` = 1, `inv` = 0.
- Sweep: `A` = 0..9, one per cycle, `lt_n`/`bl_n`/`rbi_n` = 1 -> each pattern from the table appears one cycle after its input (e.g. `A` = 2 -> 1101101, `A` = 9 -> 1111011).
- Out of range: `A` = 12 -> without HEX_EN, 0000000 with `inv` = 1; with HEX_EN, 1001110 with `inv` = 0.
- Overrides: `A` = 1 with `lt_n` = 0 -> 1111111. `A` = 1 with `bl_n` = 0 -> 0000000. `lt_n` = 0 and `bl_n` = 0 together -> 1111111.
- Ripple blank: `A` = 0, `rbi_n` = 0 -> 0000000, `rbo_n` = 0. `A` = 0, `rbi_n` = 1 -> 1111110, `rbo_n` = 1. `A` = 5, `rbi_n` = 0 -> 1011011, `rbo_n` = 1.
- Mid-run reset: during the sweep, pulse `rst_n` low for 1 cycle at `A` = 6 -> that cycle's outputs are 0000000, then the decode resumes on the next edge.

Source files
------------

// File: rtl/seven_segment_display.sv
// Registered BCD/hex to seven-segment decoder with lamp-test, blanking and ripple-blanking.
// Optional build macro SEVEN_SEG_HEX_EN enables hex glyphs for codes 10..15.
module seven_segment_display (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic       lt_n,
  input  logic       bl_n,
  input  logic       rbi_n,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       rbo_n,
  output logic       inv
);

  localparam int unsigned SEG_W = 7;

  logic [SEG_W-1:0] pattern;
  logic [SEG_W-1:0] seg_next;
  logic [SEG_W-1:0] seg_q;
  logic             supported;
  logic             rbo_next;

  // Glyph lookup, segment order {a,b,c,d,e,f,g}
  always_comb begin
    pattern   = '0;
    supported = 1'b1;
    case (A)
      4'd0:    pattern = 7'b1111110;
      4'd1:    pattern = 7'b0110000;
      4'd2:    pattern = 7'b1101101;
      4'd3:    pattern = 7'b1111001;
      4'd4:    pattern = 7'b0110011;
      4'd5:    pattern = 7'b1011011;
      4'd6:    pattern = 7'b1011111;
      4'd7:    pattern = 7'b1110000;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1111011;
`ifdef SEVEN_SEG_HEX_EN
      4'd10:   pattern = 7'b1110111;
      4'd11:   pattern = 7'b0011111;
      4'd12:   pattern = 7'b1001110;
      4'd13:   pattern = 7'b0111101;
      4'd14:   pattern = 7'b1001111;
      default: pattern = 7'b1000111;
`else
      default: begin
        pattern   = '0;
        supported = 1'b0;
      end
`endif
    endcase
  end

  // Override priority: lamp test beats blank beats ripple blank
  always_comb begin
    seg_next = pattern;
    rbo_next = 1'b1;
    if (!lt_n) begin
      seg_next = '1;
    end else if (!bl_n) begin
      seg_next = '0;
    end else if (!rbi_n && (A == 4'd0)) begin
      seg_next = '0;
      rbo_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= '0;
      rbo_n <= 1'b1;
      inv   <= 1'b0;
    end else begin
      seg_q <= seg_next;
      rbo_n <= rbo_next;
      inv   <= ~supported;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_seven_segment_display.sv
// Directed self-checking bench for seven_segment_display; compares {segments, rbo_n, inv}.
module tb_seven_segment_display;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic       lt_n;
  logic       bl_n;
  logic       rbi_n;
  logic       a, b, c, d, e, f, g;
  logic       rbo_n;
  logic       inv;

  logic [8:0] obs;
  int         n_cmp;
  int         n_fail;

  assign obs = {a, b, c, d, e, f, g, rbo_n, inv};

  seven_segment_display dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .lt_n  (lt_n),
    .bl_n  (bl_n),
    .rbi_n (rbi_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .rbo_n (rbo_n),
    .inv   (inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] digit_seg(input int v);
    case (v)
      0:       return 7'b1111110;
      1:       return 7'b0110000;
      2:       return 7'b1101101;
      3:       return 7'b1111001;
      4:       return 7'b0110011;
      5:       return 7'b1011011;
      6:       return 7'b1011111;
      7:       return 7'b1110000;
      8:       return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  task automatic drive(input logic [3:0] code, input logic lt, input logic bl, input logic rbi);
    A     = code;
    lt_n  = lt;
    bl_n  = bl;
    rbi_n = rbi;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    exp   = {7'b0000000, 1'b1, 1'b0};
    rst_n = 1'b0;
    drive(4'd8, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_sweep();
    logic [8:0] exp;
    logic [8:0] prev;
    rst_n = 1'b1;
    drive(4'd0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    prev = {digit_seg(0), 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(4'(i), 1'b1, 1'b1, 1'b1);
      if (i == 6) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp = {7'b0000000, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL midrun_reset got=%b exp=%b", obs, exp);
        end
        rst_n = 1'b1;
        prev  = exp;
      end
      #3;
      n_cmp++;
      if (obs !== prev) begin
        n_fail++;
        $display("FAIL latency_hold[%0d] got=%b exp=%b", i, obs, prev);
      end
      exp = {digit_seg(i), 1'b1, 1'b0};
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL sweep[%0d] got=%b exp=%b", i, obs, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] codes [4];
    logic       lts   [4];
    logic       bls   [4];
    logic       rbis  [4];
    logic [8:0] exps  [4];
    codes = '{4'd12, 4'd10, 4'd12, 4'd15};
    lts   = '{1'b1, 1'b0, 1'b1, 1'b1};
    bls   = '{1'b1, 1'b1, 1'b0, 1'b1};
    rbis  = '{1'b1, 1'b1, 1'b1, 1'b0};
`ifdef SEVEN_SEG_HEX_EN
    exps  = '{{7'b1001110, 1'b1, 1'b0}, {7'b1111111, 1'b1, 1'b0},
              {7'b0000000, 1'b1, 1'b0}, {7'b1000111, 1'b1, 1'b0}};
`else
    exps  = '{{7'b0000000, 1'b1, 1'b1}, {7'b1111111, 1'b1, 1'b1},
              {7'b0000000, 1'b1, 1'b1}, {7'b0000000, 1'b1, 1'b1}};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(codes[i], lts[i], bls[i], rbis[i]);
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exps[i]) begin
        n_fail++;
        $display("FAIL out_of_range[%0d] got=%b exp=%b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_overrides();
    logic [3:0] codes [5];
    logic       lts   [5];
    logic       bls   [5];
    logic       rbis  [5];
    logic [8:0] exps  [5];
    codes = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
    lts   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bls   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    rbis  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exps  = '{{7'b1111111, 1'b1, 1'b0}, {7'b0000000, 1'b1, 1'b0},
              {7'b1111111, 1'b1, 1'b0}, {7'b1111111, 1'b1, 1'b0},
              {7'b0000000, 1'b1, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      drive(codes[i], lts[i], bls[i], rbis[i]);
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exps[i]) begin
        n_fail++;
        $display("FAIL override[%0d] got=%b exp=%b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_ripple_blank();
    logic [3:0] codes [3];
    logic       rbis  [3];
    logic [8:0] exps  [3];
    codes = '{4'd0, 4'd0, 4'd5};
    rbis  = '{1'b0, 1'b1, 1'b0};
    exps  = '{{7'b0000000, 1'b0, 1'b0}, {7'b1111110, 1'b1, 1'b0},
              {7'b1011011, 1'b1, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      drive(codes[i], 1'b1, 1'b1, rbis[i]);
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exps[i]) begin
        n_fail++;
        $display("FAIL ripple[%0d] got=%b exp=%b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [6];
    logic       rbis  [6];
    logic [8:0] exps  [6];
    codes = '{4'd3, 4'd0, 4'd8, 4'd0, 4'd4, 4'd7};
    rbis  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exps  = '{{7'b1111001, 1'b1, 1'b0}, {7'b0000000, 1'b0, 1'b0},
              {7'b1111111, 1'b1, 1'b0}, {7'b1111110, 1'b1, 1'b0},
              {7'b0110011, 1'b1, 1'b0}, {7'b1110000, 1'b1, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      drive(codes[i], 1'b1, 1'b1, rbis[i]);
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== exps[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] got=%b exp=%b", i, obs, exps[i]);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(4'd0, 1'b1, 1'b1, 1'b1);
    test_reset();
    test_sweep();
    test_out_of_range();
    test_overrides();
    test_ripple_blank();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
